vscale_dmem_responder: RTL and testbench

Single-port data-memory responder that terminates the core's dmem request interface. It accepts address-phase requests from the pipeline, applies a programmable number of wait states and returns read data or commits write data in the following data phase. It also flags out-of-range and misaligned accesses on `dmem_badmem_e`. It sits beside the core in the platform top, in place of the test-harness memory model, and is the synthesizable target-side counterpart of the pipeline's dmem initiator.

---
 rtl/vscale_dmem_responder_if.sv | 36 +++
 rtl/vscale_dmem_responder.sv | 176 +++++++++++++++++
 tb/tb_vscale_dmem_responder.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vscale_dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : vscale_dmem_responder_if
// Purpose  : dmem request/response bundle between the core (master) and the
//            data-memory responder (slave).
// Signals  : dmem_en            - address-phase request valid
//            dmem_wen           - 1 = store, 0 = load
//            dmem_size[2:0]     - access size in [1:0], bit 2 = unsigned load
//            dmem_addr[31:0]    - byte address, address phase
//            dmem_wdata_delayed - store data, data phase, lanes replicated
//            dmem_rdata[31:0]   - aligned read word, completion cycle
//            dmem_wait          - data phase not yet complete
//            dmem_badmem_e      - access error, completion cycle
// Revision : 1.0 - initial release
// ============================================================================
interface vscale_dmem_responder_if;
  logic        dmem_en;
  logic        dmem_wen;
  logic [2:0]  dmem_size;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata_delayed;
  logic [31:0] dmem_rdata;
  logic        dmem_wait;
  logic        dmem_badmem_e;

  modport master (
    output dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata_delayed,
    input  dmem_rdata, dmem_wait, dmem_badmem_e
  );

  modport slave (
    input  dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata_delayed,
    output dmem_rdata, dmem_wait, dmem_badmem_e
  );
endinterface
`default_nettype wire

// File: rtl/vscale_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : vscale_dmem_responder
// Purpose  : Single-port data memory terminating the core's dmem interface.
//            Requests are captured in the address phase, held for
//            WAIT_CYCLES wait states, then completed: loads return the
//            aligned word, stores commit their byte lanes, and out-of-range
//            or misaligned accesses raise dmem_badmem_e instead.
// Ports    : clk     - clock, all state on the rising edge
//            reset_n - asynchronous active-low reset
//            dmem    - dmem bundle, slave side
// Revision : 1.0 - initial release
// ============================================================================
module vscale_dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  wire logic              clk,
  input  wire logic              reset_n,
  vscale_dmem_responder_if.slave dmem
);

  localparam int unsigned c_IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned c_OFF_W = c_IDX_W + 2;
  localparam logic [31:0] c_SPAN  = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  c_WAIT  = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,   // no phase pending
    S_WAIT = 2'd1,   // phase pending, wait states remaining
    S_DONE = 2'd2    // completion cycle
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [3:0]           r_wait_cnt;
  logic [3:0]           w_wait_cnt_nxt;

  // Data-phase registers captured at accept
  logic                 r_wen;
  logic [1:0]           r_size;
  logic [1:0]           r_byte;
  logic                 r_err;
  logic [c_IDX_W-1:0]   r_idx;
  logic [31:0]          r_rdata_q;

  logic [31:0]          r_mem [DEPTH_WORDS];

  logic [31:0]          w_off;
  logic                 w_in_range;
  logic                 w_misalign;
  logic                 w_err;
  logic [c_IDX_W-1:0]   w_idx;
  logic                 w_accept;
  logic                 w_done;
  logic                 w_commit;
  logic [3:0]           w_mask;
  logic [31:0]          w_rd_word;
  logic [31:0]          w_fwd_word;
  logic                 w_unused_ok;

  // Bit 2 of size only selects sign extension, which the core performs.
  assign w_unused_ok = dmem.dmem_size[2];

  // Addresses below BASE_ADDR wrap to large offsets, so one unsigned compare
  // covers both ends of the window.
  assign w_off      = dmem.dmem_addr - BASE_ADDR;
  assign w_in_range = (w_off < c_SPAN);
  assign w_idx      = w_off[c_OFF_W-1:2];

  always_comb begin
    w_misalign = 1'b0;
    case (dmem.dmem_size[1:0])
      2'd1:    w_misalign = w_off[0];
      2'd2:    w_misalign = (w_off[1:0] != 2'd0);
      2'd3:    w_misalign = 1'b1;
      default: w_misalign = 1'b0;
    endcase
  end

  assign w_err    = ~w_in_range | w_misalign;
  assign w_accept = dmem.dmem_en & (r_state != S_WAIT);
  assign w_done   = (r_state == S_DONE);
  assign w_commit = w_done & r_wen & ~r_err;

  always_comb begin
    w_mask = 4'b1111;
    case (r_size)
      2'd0:    w_mask = 4'b0001 << r_byte;
      2'd1:    w_mask = r_byte[1] ? 4'b1100 : 4'b0011;
      default: w_mask = 4'b1111;
    endcase
  end

  // A load accepted on the edge where a store to the same word commits must
  // observe the store, so the committing lanes are merged into the read.
  assign w_rd_word = r_mem[w_idx];

  always_comb begin
    w_fwd_word = w_rd_word;
    for (int b = 0; b < 4; b++) begin
      if (w_commit && (r_idx == w_idx) && w_mask[b]) begin
        w_fwd_word[8*b +: 8] = dmem.dmem_wdata_delayed[8*b +: 8];
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    case (r_state)
      S_WAIT: begin
        w_wait_cnt_nxt = r_wait_cnt - 4'd1;
        if (r_wait_cnt == 4'd1) begin
          w_state_nxt = S_DONE;
        end
      end
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          w_wait_cnt_nxt = c_WAIT;
          w_state_nxt    = (c_WAIT == 4'd0) ? S_DONE : S_WAIT;
        end else begin
          w_state_nxt    = S_IDLE;
        end
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_wait_cnt_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 4'd0;
      r_wen      <= 1'b0;
      r_size     <= 2'd0;
      r_byte     <= 2'd0;
      r_err      <= 1'b0;
      r_idx      <= '0;
      r_rdata_q  <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_accept) begin
        r_wen     <= dmem.dmem_wen;
        r_size    <= dmem.dmem_size[1:0];
        r_byte    <= w_off[1:0];
        r_err     <= w_err;
        r_idx     <= w_idx;
        // Faulting accesses never use the (truncated) index.
        r_rdata_q <= (w_err | dmem.dmem_wen) ? 32'd0 : w_fwd_word;
      end
    end
  end

  // Array is not reset; a write pending at reset is dropped because the
  // state register is already IDLE while reset_n is low.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_mask[b]) begin
          r_mem[r_idx][8*b +: 8] <= dmem.dmem_wdata_delayed[8*b +: 8];
        end
      end
    end
  end

  assign dmem.dmem_wait     = (r_state == S_WAIT);
  assign dmem.dmem_badmem_e = w_done & r_err;
  assign dmem.dmem_rdata    = (w_done & ~r_wen & ~r_err) ? r_rdata_q : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_vscale_dmem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_vscale_dmem_responder
// Purpose  : Self-checking bench for vscale_dmem_responder. Five instances
//            with different wait-state counts share stimulus; only the
//            selected one sees dmem_en. Expected results come from a
//            byte-array model and are queued at accept time.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vscale_dmem_responder;

  localparam int NDUT = 5;

  logic        clk = 1'b0;
  logic        reset_n;
  int          sel;
  logic        en;
  logic        wen;
  logic [2:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic [31:0] rdata_a [NDUT];
  logic        wait_a  [NDUT];
  logic        bad_a   [NDUT];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    vscale_dmem_responder_if bus ();
    assign bus.dmem_en            = en && (sel == gi);
    assign bus.dmem_wen           = wen;
    assign bus.dmem_size          = size;
    assign bus.dmem_addr          = addr;
    assign bus.dmem_wdata_delayed = wdata;
    assign rdata_a[gi]            = bus.dmem_rdata;
    assign wait_a[gi]             = bus.dmem_wait;
    assign bad_a[gi]              = bus.dmem_badmem_e;

    vscale_dmem_responder #(
      .DEPTH_WORDS (1024),
      .BASE_ADDR   (32'h0000_2000),
      .WAIT_CYCLES ((gi == 4) ? 5 : gi)
    ) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .dmem    (bus.slave)
    );
  end

  function automatic int wait_of(input int i);
    return (i == 4) ? 5 : i;
  endfunction

  typedef struct {
    logic [31:0] exp_rdata;
    logic        exp_bad;
    logic [31:0] wdata;
    int          waited;
    int          id;
  } sb_t;

  sb_t        sb [$];
  logic [7:0] model [NDUT][256];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         op_id    = 0;

  // Reference: byte-addressed memory, errors leave it untouched.
  task automatic predict(input logic w, input logic [2:0] sz, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] r, output logic b);
    logic [31:0] off;
    logic [3:0]  m;
    int          base;
    off = a - 32'h2000;
    b = (off >= 32'd4096) || (sz[1:0] == 2'd1 && a[0]) ||
        (sz[1:0] == 2'd2 && a[1:0] != 2'd0) || (sz[1:0] == 2'd3);
    r = 32'd0;
    if (!b && off < 32'd256) begin
      base = int'(off[7:2]) * 4;
      case (sz[1:0])
        2'd0:    m = 4'b0001 << a[1:0];
        2'd1:    m = a[1] ? 4'b1100 : 4'b0011;
        default: m = 4'b1111;
      endcase
      if (w) begin
        for (int k = 0; k < 4; k++)
          if (m[k]) model[sel][base+k] = d[8*k +: 8];
      end else begin
        r = {model[sel][base+3], model[sel][base+2], model[sel][base+1], model[sel][base]};
      end
    end
  endtask

  task automatic set_wdata();
    wdata = (sb.size() > 0) ? sb[0].wdata : $urandom;
  endtask

  // One cycle: check completion (or idle outputs) at negedge, report whether
  // the request on the bus gets accepted at the following posedge.
  task automatic step(output bit acc);
    sb_t e;
    @(negedge clk);
    if (sb.size() > 0) begin
      if (wait_a[sel]) begin
        sb[0].waited = sb[0].waited + 1;
      end else begin
        e = sb.pop_front();
        n_checks++;
        if (rdata_a[sel] !== e.exp_rdata) begin
          n_fail++;
          $display("FAIL rdata op%0d dut%0d: got %h expected %h", e.id, sel, rdata_a[sel], e.exp_rdata);
        end
        n_checks++;
        if (bad_a[sel] !== e.exp_bad) begin
          n_fail++;
          $display("FAIL badmem op%0d dut%0d: got %b expected %b", e.id, sel, bad_a[sel], e.exp_bad);
        end
        n_checks++;
        if (e.waited != wait_of(sel)) begin
          n_fail++;
          $display("FAIL wait_len op%0d dut%0d: got %0d expected %0d", e.id, sel, e.waited, wait_of(sel));
        end
      end
    end else begin
      n_checks++;
      if ({wait_a[sel], bad_a[sel], rdata_a[sel]} !== 34'd0) begin
        n_fail++;
        $display("FAIL idle_outputs dut%0d: got wait=%b bad=%b rdata=%h expected all 0",
                 sel, wait_a[sel], bad_a[sel], rdata_a[sel]);
      end
    end
    acc = en && !wait_a[sel];
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic w, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
    bit          acc;
    int          guard;
    sb_t         e;
    logic [31:0] r;
    logic        b;
    en = 1'b1; wen = w; size = sz; addr = a;
    acc = 1'b0; guard = 0;
    while (!acc && guard < 64) begin
      step(acc);
      guard++;
    end
    if (!acc) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout dut%0d: got no accept expected accept within 64 cycles", sel);
    end else begin
      predict(w, sz, a, d, r, b);
      e.exp_rdata = r; e.exp_bad = b; e.wdata = d; e.waited = 0; e.id = op_id++;
      sb.push_back(e);
    end
    en = 1'b0;
    set_wdata();
  endtask

  task automatic idle(input int n);
    bit acc;
    en = 1'b0;
    for (int i = 0; i < n; i++) begin
      step(acc);
      set_wdata();
    end
  endtask

  task automatic drain();
    bit acc;
    int guard;
    en = 1'b0; guard = 0;
    while (sb.size() > 0 && guard < 64) begin
      step(acc);
      set_wdata();
      guard++;
    end
    if (sb.size() > 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout dut%0d: got %0d pending expected 0", sel, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; en = 1'b0; wen = 1'b0; size = 3'd0; addr = 32'd0; wdata = 32'd0; sel = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NDUT; i++) begin
      n_checks++;
      if ({wait_a[i], bad_a[i], rdata_a[i]} !== 34'd0) begin
        n_fail++;
        $display("FAIL reset_outputs dut%0d: got wait=%b bad=%b rdata=%h expected all 0",
                 i, wait_a[i], bad_a[i], rdata_a[i]);
      end
    end
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    idle(2);
  endtask

  task automatic test_word_rw();
    sel = 0;
    send(1'b1, 3'd2, 32'h2010, 32'hDEADBEEF);
    send(1'b0, 3'd2, 32'h2010, 32'h0);
    drain();
  endtask

  task automatic test_lanes();
    sel = 0;
    send(1'b1, 3'd2, 32'h2020, 32'h11223344);
    send(1'b1, 3'd0, 32'h2021, 32'hAAAAAAAA);
    send(1'b1, 3'd1, 32'h2022, 32'h55665566);
    send(1'b0, 3'd2, 32'h2020, 32'h0);
    drain();
    // Same sequence with a wait state between accept and commit.
    sel = 1;
    send(1'b1, 3'd2, 32'h2020, 32'h11223344);
    send(1'b1, 3'd0, 32'h2021, 32'hAAAAAAAA);
    send(1'b1, 3'd1, 32'h2022, 32'h55665566);
    send(1'b0, 3'd6, 32'h2020, 32'h0);
    drain();
  endtask

  task automatic test_wait_states();
    sel = 3;
    send(1'b1, 3'd2, 32'h2030, 32'h0BADF00D);
    send(1'b0, 3'd2, 32'h2030, 32'h0);
    idle(3);
    send(1'b0, 3'd2, 32'h2030, 32'h0);
    drain();
    idle(2);
  endtask

  task automatic test_errors();
    sel = 0;
    send(1'b1, 3'd2, 32'h2000, 32'hCAFEF00D);
    send(1'b0, 3'd2, 32'h2002, 32'h0);
    send(1'b1, 3'd1, 32'h2001, 32'hFFFFFFFF);
    send(1'b0, 3'd2, 32'h1FFC, 32'h0);
    send(1'b0, 3'd2, 32'h3000, 32'h0);
    send(1'b1, 3'd3, 32'h2000, 32'hFFFFFFFF);
    send(1'b0, 3'd2, 32'h2000, 32'h0);
    drain();
  endtask

  task automatic test_reset_mid_op();
    sel = 2;
    send(1'b1, 3'd2, 32'h2040, 32'hA5A5A5A5);
    drain();
    send(1'b1, 3'd2, 32'h2040, 32'h12345678);
    n_checks++;
    if (wait_a[sel] !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_wait: got %b expected 1", wait_a[sel]);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({wait_a[sel], bad_a[sel], rdata_a[sel]} !== 34'd0) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got wait=%b bad=%b rdata=%h expected all 0",
               wait_a[sel], bad_a[sel], rdata_a[sel]);
    end
    // The store was dropped: forget it and put back the prior contents.
    sb.delete();
    model[sel][8'h40] = 8'hA5; model[sel][8'h41] = 8'hA5;
    model[sel][8'h42] = 8'hA5; model[sel][8'h43] = 8'hA5;
    @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    set_wdata();
    idle(3);
    send(1'b0, 3'd2, 32'h2040, 32'h0);
    drain();
  endtask

  task automatic test_back_to_back(input int s, input int n);
    sel = s;
    for (int i = 0; i < 64; i++) send(1'b1, 3'd2, 32'h2000 + 32'(i * 4), $urandom);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      logic [2:0]  sz;
      if ($urandom_range(0, 99) < 3)
        a = ($urandom_range(0, 1) == 0) ? 32'h1FF0 + 32'($urandom_range(0, 15))
                                        : 32'h3000 + 32'($urandom_range(0, 15));
      else
        a = 32'h2000 + 32'($urandom_range(0, 255));
      sz[1:0] = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      sz[2]   = 1'($urandom_range(0, 1));
      send(1'($urandom_range(0, 1)), sz, a, $urandom);
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
    end
    drain();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_word_rw();
    test_lanes();
    test_wait_states();
    test_errors();
    test_reset_mid_op();
    test_back_to_back(0, 3300);
    test_back_to_back(1, 3300);
    test_back_to_back(4, 3400);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
